// File: rtl/insert_order_pkg.sv
// Shared order-book constants, entry/memory types and the insert_order state encoding.
package insert_order_pkg;

  localparam int ORDER_INDEX    = 7;
  localparam int QUANTITY_INDEX = 15;
  localparam int PRICE_INDEX    = 15;
  localparam int MAX_ORDERS     = 8;
  localparam int SIZE_INDEX     = 3;

  localparam logic BUY_SIDE  = 1'b0;
  localparam logic SELL_SIDE = 1'b1;

  localparam int ADD_UPDATE_INDEX = 1;
  localparam logic [ADD_UPDATE_INDEX:0] ADD_NONE     = 2'd0;
  localparam logic [ADD_UPDATE_INDEX:0] ADD_INSERTED = 2'd1;
  localparam logic [ADD_UPDATE_INDEX:0] ADD_FULL     = 2'd2;

  typedef logic [SIZE_INDEX:0] size_t;
  localparam size_t MAX_SIZE = size_t'(MAX_ORDERS);
  localparam size_t ONE      = size_t'(1);

  typedef struct packed {
    logic [PRICE_INDEX:0]    price;
    logic [ORDER_INDEX:0]    order_id;
    logic [QUANTITY_INDEX:0] quantity;
  } book_entry;

  typedef struct packed {
    book_entry first;
  } read_result;

  // Addresses share the size width so the slot just past the tail is representable.
  typedef struct packed {
    size_t addr;
    logic  is_write;
    logic  start;
  } mem_struct;

  typedef enum logic [2:0] {
    IDLE,
    TAIL,
    FIND,
    SHIFT_RD,
    SHIFT_WR,
    PLACE,
    DONE
  } state_t;

  function automatic mem_struct mem_cmd(input size_t addr, input logic is_write);
    mem_struct m;
    m.addr     = addr;
    m.is_write = is_write;
    m.start    = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/insert_order_if.sv
// Request, memory-port and completion signals between order_book and insert_order.
interface insert_order_if;
  import insert_order_pkg::*;

  // start: one-cycle request, taken only when idle. mem_control.start: one-cycle
  // memory request; addr/is_write/data_w hold until mem_valid, next request comes
  // no earlier than the cycle after mem_valid. ready: one-cycle completion pulse.
  logic                          start;
  logic [ORDER_INDEX:0]          id;
  logic [QUANTITY_INDEX:0]       quantity;
  logic [PRICE_INDEX:0]          price;
  size_t                         size;
  logic                          mem_valid;
  read_result                    data_r;
  mem_struct                     mem_control;
  book_entry                     data_w;
  logic                          ready;
  size_t                         size_update_o;
  logic [ADD_UPDATE_INDEX:0]     update;

  modport master (
    output start, id, quantity, price, size, mem_valid, data_r,
    input  mem_control, data_w, ready, size_update_o, update
  );

  modport slave (
    input  start, id, quantity, price, size, mem_valid, data_r,
    output mem_control, data_w, ready, size_update_o, update
  );

endinterface

// File: rtl/insert_order_price_better.sv
// Strict price-priority compare: buy side prefers higher prices, sell side lower.
module price_better
  import insert_order_pkg::*;
#(
  parameter logic SIDE = BUY_SIDE
) (
  input  logic [PRICE_INDEX:0] new_price,
  input  logic [PRICE_INDEX:0] book_price,
  output logic                 better
);

  // Equal prices never win, which keeps earlier orders ahead at the same level.
  assign better = (SIDE == BUY_SIDE) ? (new_price > book_price)
                                     : (new_price < book_price);

endmodule

// File: rtl/insert_order.sv
// Inserts a resting order into one side of the book, preserving price-time priority.
// Optional INSERT_TAIL_CHECK_EN: probe the tail entry first and append directly when possible.
module insert_order
  import insert_order_pkg::*;
#(
  parameter logic SIDE = BUY_SIDE
) (
  input  logic          clk_in,
  input  logic          rst_in,
  insert_order_if.slave bus,
  output state_t        dbg_state
);

  state_t    state;
  book_entry entry_l;
  book_entry new_entry;
  book_entry rd_entry;
  size_t     size_l;
  size_t     index;
  size_t     ins;
  size_t     j;
  logic      full_l;
  logic      beats;

  always_comb begin
    new_entry          = '0;
    new_entry.price    = bus.price;
    new_entry.order_id = bus.id;
    new_entry.quantity = bus.quantity;
  end

  assign rd_entry  = bus.data_r.first;
  assign dbg_state = state;

  price_better #(.SIDE(SIDE)) u_better (
    .new_price  (entry_l.price),
    .book_price (rd_entry.price),
    .better     (beats)
  );

  // Every memory request is launched on the edge that leaves the previous step,
  // so each waiting state only has to watch for mem_valid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      bus.mem_control   <= '0;
      bus.data_w        <= '0;
      bus.ready         <= 1'b0;
      bus.update        <= ADD_NONE;
      bus.size_update_o <= '0;
      entry_l           <= '0;
      size_l            <= '0;
      index             <= '0;
      ins               <= '0;
      j                 <= '0;
      full_l            <= 1'b0;
    end else begin
      bus.mem_control.start <= 1'b0;
      bus.ready             <= 1'b0;
      case (state)
        IDLE: begin
          bus.update <= ADD_NONE;
          bus.data_w <= '0;
          if (bus.start) begin
            entry_l <= new_entry;
            size_l  <= bus.size;
            index   <= '0;
            ins     <= '0;
            full_l  <= 1'b0;
            if (bus.size == MAX_SIZE) begin
              full_l <= 1'b1;
              state  <= DONE;
            end else if (bus.size == '0) begin
              bus.mem_control <= mem_cmd('0, 1'b1);
              bus.data_w      <= new_entry;
              state           <= PLACE;
            end else begin
`ifdef INSERT_TAIL_CHECK_EN
              bus.mem_control <= mem_cmd(bus.size - ONE, 1'b0);
              state           <= TAIL;
`else
              bus.mem_control <= mem_cmd('0, 1'b0);
              state           <= FIND;
`endif
            end
          end
        end

`ifdef INSERT_TAIL_CHECK_EN
        TAIL: begin
          if (bus.mem_valid) begin
            if (beats) begin
              index           <= '0;
              bus.mem_control <= mem_cmd('0, 1'b0);
              state           <= FIND;
            end else begin
              ins             <= size_l;
              bus.mem_control <= mem_cmd(size_l, 1'b1);
              bus.data_w      <= entry_l;
              state           <= PLACE;
            end
          end
        end
`endif

        FIND: begin
          if (bus.mem_valid) begin
            if (beats) begin
              ins             <= index;
              j               <= size_l - ONE;
              bus.mem_control <= mem_cmd(size_l - ONE, 1'b0);
              state           <= SHIFT_RD;
            end else if (index + ONE == size_l) begin
              ins             <= size_l;
              bus.mem_control <= mem_cmd(size_l, 1'b1);
              bus.data_w      <= entry_l;
              state           <= PLACE;
            end else begin
              index           <= index + ONE;
              bus.mem_control <= mem_cmd(index + ONE, 1'b0);
            end
          end
        end

        SHIFT_RD: begin
          if (bus.mem_valid) begin
            bus.mem_control <= mem_cmd(j + ONE, 1'b1);
            bus.data_w      <= rd_entry;
            state           <= SHIFT_WR;
          end
        end

        // j never drops below ins, so stopping on equality avoids unsigned wrap at ins = 0.
        SHIFT_WR: begin
          if (bus.mem_valid) begin
            if (j == ins) begin
              bus.mem_control <= mem_cmd(ins, 1'b1);
              bus.data_w      <= entry_l;
              state           <= PLACE;
            end else begin
              j               <= j - ONE;
              bus.mem_control <= mem_cmd(j - ONE, 1'b0);
              state           <= SHIFT_RD;
            end
          end
        end

        PLACE: begin
          if (bus.mem_valid) begin
            state <= DONE;
          end
        end

        DONE: begin
          bus.ready         <= 1'b1;
          bus.update        <= full_l ? ADD_FULL : ADD_INSERTED;
          bus.size_update_o <= full_l ? size_l : size_l + ONE;
          state             <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insert_order.sv
// Scoreboard bench for insert_order: buy and sell instances share one memory model.
`timescale 1ns/1ps
module tb_insert_order;
  import insert_order_pkg::*;

  typedef logic [PRICE_INDEX:0]    price_t;
  typedef logic [ORDER_INDEX:0]    id_t;
  typedef logic [QUANTITY_INDEX:0] qty_t;

  localparam int MW = 1 + SIZE_INDEX + 1 + $bits(book_entry);
  localparam int DW = ADD_UPDATE_INDEX + 1 + SIZE_INDEX + 1 + 32;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  insert_order_if bus_b ();
  insert_order_if bus_s ();

  logic       start = 1'b0;
  logic       sel = 1'b0;
  id_t        id_v = '0;
  qty_t       qty_v = '0;
  price_t     price_v = '0;
  size_t      size_v = '0;
  logic       mem_valid;
  read_result rd;
  state_t     st_b;
  state_t     st_s;

  assign bus_b.start     = start & ~sel;
  assign bus_s.start     = start & sel;
  assign bus_b.id        = id_v;
  assign bus_s.id        = id_v;
  assign bus_b.quantity  = qty_v;
  assign bus_s.quantity  = qty_v;
  assign bus_b.price     = price_v;
  assign bus_s.price     = price_v;
  assign bus_b.size      = size_v;
  assign bus_s.size      = size_v;
  assign bus_b.mem_valid = mem_valid;
  assign bus_s.mem_valid = mem_valid;
  assign bus_b.data_r    = rd;
  assign bus_s.data_r    = rd;

  insert_order #(.SIDE(BUY_SIDE)) dut_b (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bus       (bus_b),
    .dbg_state (st_b)
  );

  insert_order #(.SIDE(SELL_SIDE)) dut_s (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .bus       (bus_s),
    .dbg_state (st_s)
  );

  mem_struct                 mc;
  book_entry                 dw;
  logic                      rdy;
  logic [ADD_UPDATE_INDEX:0] upd;
  size_t                     szu;
  assign mc  = sel ? bus_s.mem_control   : bus_b.mem_control;
  assign dw  = sel ? bus_s.data_w        : bus_b.data_w;
  assign rdy = sel ? bus_s.ready         : bus_b.ready;
  assign upd = sel ? bus_s.update        : bus_b.update;
  assign szu = sel ? bus_s.size_update_o : bus_b.size_update_o;

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  logic [DW-1:0] exp_done_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic chk_mem = 1'b1;
  int lat = 1;
  book_entry mem [16];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic book_entry be(input price_t p, input id_t i, input qty_t q);
    book_entry e;
    e.price = p;
    e.order_id = i;
    e.quantity = q;
    return e;
  endfunction

  function automatic logic [MW-1:0] txn(input logic w, input size_t a, input book_entry d);
    return {w, a, w ? d : book_entry'('0)};
  endfunction

  task automatic push_rd(input size_t a);
    exp_q.push_back(txn(1'b0, a, '0));
  endtask

  task automatic push_wr(input size_t a, input price_t p, input id_t i, input qty_t q);
    exp_q.push_back(txn(1'b1, a, be(p, i, q)));
  endtask

  // ---------------- memory model ----------------
  initial begin
    size_t     a_q;
    logic      w_q;
    book_entry d_q;
    logic      abort;
    mem_valid = 1'b0;
    rd = '0;
    forever begin
      @(negedge clk_in);
      mem_valid = 1'b0;
      if (mc.start && !rst_in) begin
        a_q = mc.addr;
        w_q = mc.is_write;
        d_q = dw;
        abort = 1'b0;
        for (int k = 0; k < lat; k++) begin
          @(negedge clk_in);
          if (rst_in) abort = 1'b1;
        end
        if (!abort) begin
          if (w_q) mem[a_q] = d_q;
          else rd.first = mem[a_q];
          mem_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic          pend;
    size_t         p_addr;
    logic          p_wr;
    logic [DW-1:0] e;
    pend = 1'b0;
    p_addr = '0;
    p_wr = 1'b0;
    forever begin
      @(negedge clk_in);
      #1;
      if (rst_in) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cmp("hs_single_start", 64'(mc.start), 64'(0));
          cmp("hs_hold", 64'({mc.addr, mc.is_write}), 64'({p_addr, p_wr}));
          if (mem_valid) pend = 1'b0;
        end
        if (mc.start) begin
          pend = 1'b1;
          p_addr = mc.addr;
          p_wr = mc.is_write;
          if (chk_mem) begin
            if (exp_q.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL mem_unexpected: got txn %0h, required none", txn(mc.is_write, mc.addr, dw));
            end else begin
              cmp("mem_txn", 64'(txn(mc.is_write, mc.addr, dw)), 64'(exp_q.pop_front()));
            end
          end
        end
        if (rdy) begin
          if (exp_done_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_unexpected: got ready with update %0d, required none", upd);
          end else begin
            e = exp_done_q.pop_front();
            cmp("done_update", 64'(upd), 64'(e[DW-1 -: ADD_UPDATE_INDEX+1]));
            cmp("done_size", 64'(szu), 64'(e[32 +: SIZE_INDEX+1]));
            cmp("done_cycle", 64'(cyc), 64'(e[31:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic s, input int l, input size_t sz, input price_t p,
                       input id_t i, input qty_t q, input logic [ADD_UPDATE_INDEX:0] upd_e,
                       input size_t sz_e);
    int n;
    @(negedge clk_in);
    n = exp_q.size();
    sel = s;
    lat = l;
    size_v = sz;
    price_v = p;
    id_v = i;
    qty_v = q;
    start = 1'b1;
    exp_done_q.push_back({upd_e, sz_e, 32'(cyc + 2 + n * (l + 1))});
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic pulse_start(input price_t p);
    @(negedge clk_in);
    price_v = p;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0) && n < 2000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size() + exp_done_q.size());
      exp_q.delete();
      exp_done_q.delete();
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic check_reset(input string name);
    cmp({name, "_mc_b"}, 64'(bus_b.mem_control), 64'(0));
    cmp({name, "_dw_b"}, 64'(bus_b.data_w), 64'(0));
    cmp({name, "_rdy_b"}, 64'(bus_b.ready), 64'(0));
    cmp({name, "_upd_b"}, 64'(bus_b.update), 64'(ADD_NONE));
    cmp({name, "_size_b"}, 64'(bus_b.size_update_o), 64'(0));
    cmp({name, "_state_b"}, 64'(st_b), 64'(IDLE));
    cmp({name, "_mc_s"}, 64'(bus_s.mem_control), 64'(0));
    cmp({name, "_state_s"}, 64'(st_s), 64'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_reset("reset");
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // empty buy book
    push_wr(0, 100, 1, 10);
    issue(BUY_SIDE, 2, 0, 100, 1, 10, ADD_INSERTED, 1);
    wait_done("empty");
    cmp("empty_mem0", 64'(mem[0]), 64'(be(100, 1, 10)));

    // equal price goes behind, with an ignored start while busy
    mem[0] = be(105, 11, 1);
    mem[1] = be(100, 12, 2);
    mem[2] = be(95, 13, 3);
`ifdef INSERT_TAIL_CHECK_EN
    push_rd(2);
`endif
    push_rd(0);
    push_rd(1);
    push_rd(2);
    push_rd(2);
    push_wr(3, 95, 13, 3);
    push_wr(2, 100, 7, 5);
    issue(BUY_SIDE, 1, 3, 100, 7, 5, ADD_INSERTED, 4);
    repeat (2) @(negedge clk_in);
    pulse_start(200);
    wait_done("equal");
    cmp("equal_mem1", 64'(mem[1]), 64'(be(100, 12, 2)));
    cmp("equal_mem2", 64'(mem[2]), 64'(be(100, 7, 5)));
    cmp("equal_mem3", 64'(mem[3]), 64'(be(95, 13, 3)));

    // sell book, insert at front
    for (int k = 0; k < 16; k++) mem[k] = '0;
    mem[0] = be(95, 21, 1);
    mem[1] = be(100, 22, 2);
`ifdef INSERT_TAIL_CHECK_EN
    push_rd(1);
`endif
    push_rd(0);
    push_rd(1);
    push_wr(2, 100, 22, 2);
    push_rd(0);
    push_wr(1, 95, 21, 1);
    push_wr(0, 90, 3, 4);
    issue(SELL_SIDE, 3, 2, 90, 3, 4, ADD_INSERTED, 3);
    wait_done("front");
    cmp("front_mem0", 64'(mem[0]), 64'(be(90, 3, 4)));
    cmp("front_mem1", 64'(mem[1]), 64'(be(95, 21, 1)));
    cmp("front_mem2", 64'(mem[2]), 64'(be(100, 22, 2)));

    // zero quantity, equal to sell tail, lands at the end
`ifdef INSERT_TAIL_CHECK_EN
    push_rd(2);
`else
    push_rd(0);
    push_rd(1);
    push_rd(2);
`endif
    push_wr(3, 100, 9, 0);
    issue(SELL_SIDE, 1, 3, 100, 9, 0, ADD_INSERTED, 4);
    wait_done("zero_qty");
    cmp("zero_qty_mem3", 64'(mem[3]), 64'(be(100, 9, 0)));

    // full book: no memory traffic, ready two cycles after start
    issue(BUY_SIDE, 1, MAX_SIZE, 120, 5, 1, ADD_FULL, MAX_SIZE);
    wait_done("full");

    // buy tail append
    mem[0] = be(105, 31, 1);
    mem[1] = be(100, 32, 2);
`ifdef INSERT_TAIL_CHECK_EN
    push_rd(1);
`else
    push_rd(0);
    push_rd(1);
`endif
    push_wr(2, 90, 4, 6);
    issue(BUY_SIDE, 2, 2, 90, 4, 6, ADD_INSERTED, 3);
    wait_done("tail");
    cmp("tail_mem2", 64'(mem[2]), 64'(be(90, 4, 6)));

    // reset in the middle of the shift
    mem[0] = be(105, 41, 1);
    mem[1] = be(100, 42, 2);
    mem[2] = be(95, 43, 3);
    chk_mem = 1'b0;
    @(negedge clk_in);
    sel = 1'b0;
    lat = 2;
    size_v = 3;
    price_v = 110;
    id_v = 8;
    qty_v = 1;
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    n = 0;
    while (st_b != SHIFT_WR && n < 500) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL shift_wait_timeout: got state %0d, required %0d", st_b, SHIFT_WR);
    end
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    @(posedge clk_in);
    #2;
    check_reset("mid_reset");
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    chk_mem = 1'b1;

    // empty book after reset
    push_wr(0, 50, 2, 7);
    issue(BUY_SIDE, 1, 0, 50, 2, 7, ADD_INSERTED, 1);
    wait_done("after_reset");
    cmp("after_reset_mem0", 64'(mem[0]), 64'(be(50, 2, 7)));

    cmp("exp_q_empty", 64'(exp_q.size()), 64'(0));
    cmp("exp_done_q_empty", 64'(exp_done_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
